// File: rtl/robo_ctrl.sv
// Left-hand wall-following controller: one move command per rising edge of the robot step clock.
// Optional action budget enabled by defining ROBO_CTRL_TIMEOUT_EN (counts issued commands up to MAX_ACTIONS).
module robo_ctrl #(
   parameter int MAX_ACTIONS = 1023
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic tick,
   input  logic head,
   input  logic left,
   input  logic under,
   input  logic barrier,
   output logic avancar,
   output logic girar,
   output logic remover,
   output logic done,
   output logic timeout
);

   typedef enum logic [2:0] {DECIDE, TURN_L2, TURN_L3, FWD, DONE} state_t;
   typedef enum logic [1:0] {CMD_NONE, CMD_ADV, CMD_TURN, CMD_REM} cmd_t;

   state_t state, state_nxt;
   cmd_t   cmd;
   logic   left_lock, lock_nxt;
   logic   tick_q;
   logic   step;
   logic   exit_hit;
   logic   budget_out;

   assign step = tick & ~tick_q;

   // Decision table for the current step; only consulted when a step arrives.
   always_comb begin
      cmd       = CMD_NONE;
      state_nxt = state;
      lock_nxt  = left_lock;
      exit_hit  = 1'b0;
      case (state)
         DECIDE: begin
            if (under) begin
               exit_hit = 1'b1;
            end else if (barrier) begin
               cmd = CMD_REM;
            end else if (!left && !left_lock) begin
               cmd       = CMD_TURN;
               state_nxt = TURN_L2;
            end else if (!head) begin
               cmd      = CMD_ADV;
               lock_nxt = 1'b0;
            end else begin
               cmd      = CMD_TURN;
               lock_nxt = 1'b0;
            end
         end
         TURN_L2: begin
            cmd       = CMD_TURN;
            state_nxt = TURN_L3;
         end
         TURN_L3: begin
            cmd       = CMD_TURN;
            state_nxt = FWD;
         end
         FWD: begin
            if (barrier) begin
               cmd = CMD_REM;
            end else if (!head) begin
               cmd       = CMD_ADV;
               lock_nxt  = 1'b1;
               state_nxt = DECIDE;
            end else begin
               cmd       = CMD_TURN;
               state_nxt = DECIDE;
            end
         end
         default: begin
            cmd = CMD_NONE;
         end
      endcase
   end

`ifdef ROBO_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_ACTIONS + 1);
   logic [CNT_W-1:0] count;

   assign budget_out = (count == CNT_W'(MAX_ACTIONS));

   // Counter saturates at the budget: the command that would exceed it is swallowed instead.
   always_ff @(posedge clock) begin
      if (reset) begin
         count   <= '0;
         timeout <= 1'b0;
      end else if (state != DONE && enable && step && cmd != CMD_NONE) begin
         if (budget_out) begin
            timeout <= 1'b1;
         end else begin
            count <= count + 1'b1;
         end
      end
   end
`else
   assign budget_out = 1'b0;
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= DECIDE;
         left_lock <= 1'b0;
         tick_q    <= 1'b1;
         avancar   <= 1'b0;
         girar     <= 1'b0;
         remover   <= 1'b0;
         done      <= 1'b0;
      end else begin
         tick_q  <= tick;
         avancar <= 1'b0;
         girar   <= 1'b0;
         remover <= 1'b0;
         if (state != DONE) begin
            if (!enable) begin
               state     <= DECIDE;
               left_lock <= 1'b0;
            end else if (step) begin
               if (exit_hit || (cmd != CMD_NONE && budget_out)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= state_nxt;
                  left_lock <= lock_nxt;
                  avancar   <= (cmd == CMD_ADV);
                  girar     <= (cmd == CMD_TURN);
                  remover   <= (cmd == CMD_REM);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_robo_ctrl.sv
// Bench for robo_ctrl: directed scenarios plus randomized stimulus, checked every cycle against a behavioural model.
module tb_robo_ctrl;

   localparam int MAXA = 5;

   logic clock = 1'b0;
   logic reset, enable, tick, head, left, under, barrier;
   logic avancar, girar, remover, done, timeout;

   robo_ctrl #(.MAX_ACTIONS(MAXA)) dut (
      .clock(clock), .reset(reset), .enable(enable), .tick(tick),
      .head(head), .left(left), .under(under), .barrier(barrier),
      .avancar(avancar), .girar(girar), .remover(remover),
      .done(done), .timeout(timeout)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int av_n = 0, gi_n = 0, re_n = 0;
   bit chk_on = 1'b0;

   // Model: remaining forced turns of a left turn, pending forward move, lock, exit flags.
   bit m_tq, m_done, m_to, m_lock, m_fwd;
   int m_turns, m_cnt;
   bit e_av = 1'b0, e_gi = 1'b0, e_re = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int cmd;   // 0 none, 1 forward, 2 turn, 3 remove
      bit stp;
      if (reset) begin
         m_tq = 1'b1; m_done = 1'b0; m_to = 1'b0; m_lock = 1'b0; m_fwd = 1'b0;
         m_turns = 0; m_cnt = 0; e_av = 1'b0; e_gi = 1'b0; e_re = 1'b0;
         return;
      end
      e_av = 1'b0; e_gi = 1'b0; e_re = 1'b0;
      stp  = tick && !m_tq;
      m_tq = tick;
      if (m_done) return;
      if (!enable) begin
         m_lock = 1'b0; m_fwd = 1'b0; m_turns = 0;
         return;
      end
      if (!stp) return;
      cmd = 0;
      if (m_turns > 0) begin
         cmd = 2;
         m_turns--;
         m_fwd = (m_turns == 0);
      end else if (m_fwd) begin
         if (barrier) cmd = 3;
         else begin
            m_fwd = 1'b0;
            if (!head) begin cmd = 1; m_lock = 1'b1; end
            else cmd = 2;
         end
      end else if (under) begin
         m_done = 1'b1;
         return;
      end else if (barrier) begin
         cmd = 3;
      end else if (!left && !m_lock) begin
         cmd = 2;
         m_turns = 2;
      end else begin
         cmd = head ? 2 : 1;
         m_lock = 1'b0;
      end
`ifdef ROBO_CTRL_TIMEOUT_EN
      if (cmd != 0) begin
         if (m_cnt == MAXA) begin
            m_done = 1'b1; m_to = 1'b1;
            return;
         end
         m_cnt++;
      end
`endif
      e_av = (cmd == 1); e_gi = (cmd == 2); e_re = (cmd == 3);
   endtask

   always @(negedge clock) begin
      if (chk_on) begin
         chk("avancar", 32'(avancar), 32'(e_av));
         chk("girar",   32'(girar),   32'(e_gi));
         chk("remover", 32'(remover), 32'(e_re));
         chk("done",    32'(done),    32'(m_done));
         chk("timeout", 32'(timeout), 32'(m_to));
         chk("one_cmd", 32'((32'(avancar) + 32'(girar) + 32'(remover)) <= 1), 32'd1);
         av_n += 32'(avancar);
         gi_n += 32'(girar);
         re_n += 32'(remover);
      end
   end

   task automatic cyc();
      @(posedge clock);
      model_step();
      @(negedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; tick = 1'b0;
      cyc();
      reset = 1'b0;
      cyc();
   endtask

   // One step: rising tick edge; returns {remover,girar,avancar} seen the cycle after the edge.
   task automatic pulse(output logic [2:0] got);
      tick = 1'b1;
      cyc();
      got = {remover, girar, avancar};
      tick = 1'b0;
      cyc();
      cyc();
   endtask

   logic [2:0] got;
   int base;
   logic [2:0] seq3 [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b001};

   initial begin
      reset = 1'b1; enable = 1'b1; tick = 1'b1;
      head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
      cyc();
      chk_on = 1'b1;
      cyc(); cyc();

      // Reset released with tick held high: no step appears
      reset = 1'b0;
      repeat (5) begin
         cyc();
         chk("t1_quiet", 32'({avancar, girar, remover, done, timeout}), 32'd0);
      end
      tick = 1'b0;
      cyc();

      // Wall on the left, open ahead: straight moves, one cycle each
      left = 1'b1; head = 1'b0;
      base = av_n;
      repeat (3) begin
         tick = 1'b1;
         cyc();
         chk("t2_latency", 32'(avancar), 32'd1);
         tick = 1'b0;
         cyc();
         chk("t2_width", 32'(avancar), 32'd0);
         cyc();
      end
      chk("t2_count", 32'(av_n - base), 32'd3);

      // Open left: three right-turns make a left turn, advance, then lock goes straight
      do_reset();
      left = 1'b0; head = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pulse(got);
         chk("t3_seq", 32'(got), 32'(seq3[i]));
      end

      // Debris then wall ahead
      do_reset();
      barrier = 1'b1;
      pulse(got);
      chk("t4_remove", 32'(got), 32'b100);
      barrier = 1'b0; left = 1'b1; head = 1'b1;
      pulse(got);
      chk("t4_turn", 32'(got), 32'b010);

      // Exit cell beats debris; DONE absorbs steps and enable changes
      under = 1'b1; barrier = 1'b1;
      pulse(got);
      chk("t5_exit_cmd", 32'(got), 32'd0);
      chk("t5_done", 32'(done), 32'd1);
      under = 1'b0; barrier = 1'b0; left = 1'b0; head = 1'b0;
      pulse(got);
      chk("t5_absorb", 32'(got), 32'd0);
      enable = 1'b0;
      pulse(got);
      enable = 1'b1;
      pulse(got);
      chk("t5_enable", 32'(got), 32'd0);
      chk("t5_sticky", 32'(done), 32'd1);

      // Action budget
      do_reset();
      left = 1'b1; head = 1'b0;
      for (int i = 0; i < MAXA; i++) begin
         pulse(got);
         chk("t6_adv", 32'(got), 32'b001);
      end
      pulse(got);
`ifdef ROBO_CTRL_TIMEOUT_EN
      chk("t6_over_cmd", 32'(got), 32'd0);
      chk("t6_timeout", 32'(timeout), 32'd1);
      chk("t6_done", 32'(done), 32'd1);
`else
      chk("t6_no_budget", 32'(got), 32'b001);
      chk("t6_timeout", 32'(timeout), 32'd0);
`endif

      // Disable mid left-turn: restart from DECIDE, not the pending forward move
      do_reset();
      left = 1'b0; head = 1'b0;
      pulse(got);
      chk("t6_turn1", 32'(got), 32'b010);
      pulse(got);
      chk("t6_turn2", 32'(got), 32'b010);
      enable = 1'b0;
      cyc(); cyc();
      enable = 1'b1;
      pulse(got);
      chk("t6_restart", 32'(got), 32'b010);

      // Randomized stimulus against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset   = (i % 150 == 0) || ($urandom_range(0, 299) == 0);
         enable  = ($urandom_range(0, 19) != 0);
         tick    = 1'($urandom_range(0, 1));
         head    = 1'($urandom_range(0, 1));
         left    = 1'($urandom_range(0, 1));
         barrier = ($urandom_range(0, 3) == 0);
         under   = ($urandom_range(0, 29) == 0);
         cyc();
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
